updown_modcount: RTL and testbench
==================================

# updown_modcount

Parametrised up/down counter with a programmable modulus, selectable wrap, saturate or one-shot end behaviour, a combinational cascade carry, and a registered one-shot completion flag. It is the general-purpose counting primitive for timers, prescalers and address sequencers. Wide counters are built by chaining instances through `Cout` → `E`.

## Interface
Parameters:
- `n`, 8, counter, load and modulus width in bits.

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Resetn`  in  1  reset; synchronous, active-low.
- `R`  in  n  parallel load value.
- `M`  in  n  modulus limit; counting range is 0..M inclusive.
- `L`  in  1  load strobe.
- `E`  in  1  count enable.
- `up_down`  in  1  direction: 1 counts up, 0 counts down.
- `mode`  in  2  end behaviour: 00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
- `Q`  out  n  count value, registered.
- `Cout`  out  1  boundary carry/borrow, combinational.
- `Done`  out  1  one-shot completion flag, registered.

## Operation
- Priority at each edge: `!Resetn`, then `L`, then `E`, then hold.
- Reset: `Q`=0, `Done`=0, FSM=COUNT.
- Load:
  - `Q` = min(`R`, `M`), so an out-of-range `R` is clamped.
  - `Done` is cleared and the FSM goes to COUNT in every mode.
- The boundary condition `bnd` is (`up_down` & `Q` ≥ `M`) | (!`up_down` & `Q`==0).
- Enabled step when `bnd`=0:
  - `Q` ± 1 in the selected direction.
  - Down while `Q` > `M` (after `M` was lowered): `Q` = `M`.
- Enabled step when `bnd`=1:
  - wrap: up → 0, down → `M`.
  - saturate: `Q` holds; up with `Q` > `M` → `Q` = `M`.
  - one-shot: same as saturate, and the FSM goes to DONE.
- One-shot FSM, states COUNT and DONE:
  - COUNT→DONE on an enabled step whose result equals the terminal value (`M` for up, 0 for down), or on an enabled step attempted while `bnd`=1.
  - DONE: `E` is ignored and `Q` holds. Only `L` or reset returns the FSM to COUNT.
  - In modes other than one-shot, the FSM stays in COUNT.
  - A `mode` change while in DONE does not leave DONE.
- `Done` is 1 exactly when the FSM is in DONE.
- `Cout` = `E` & !`L` & `Resetn` & (FSM==COUNT) & `bnd`. It marks the cycle in which this stage wraps or hits its limit, and drives the next stage's `E`.
- Arithmetic is modulo 2^n internally. The result is never outside 0..max(`M`, `Q`).
- `M`=0: `Q` stays 0 in every mode, and `Cout`=`E` while in COUNT.

## Timing
- `Q` and `Done` change only on the rising edge of `Clock`, with 1-cycle latency from `L`, `E` or `Resetn`.
- `Cout` has zero latency, as a function of the current `Q`, `M`, `E`, `L`, `up_down`, `Resetn` and FSM state.
- The cascade carry path is combinational across stages. The integrator constrains chain length against clock period.
- `L` and `E` asserted together: the load wins and no step occurs.
- `M` and `mode` are sampled every cycle with no hold requirement. A change takes effect at the next edge.
- Reset mid-count or while in DONE takes precedence over all other inputs at that edge.

## Structure
- Shared package `counter_pkg`:
  - mode constants `MODE_WRAP`=2'b00, `MODE_SAT`=2'b01, `MODE_ONESHOT`=2'b10.
  - FSM state encoding `ST_COUNT`=0, `ST_DONE`=1.
- The block is a single module with one always block for `Q`/FSM and continuous assigns for `bnd`, `Cout` and `Done`. No sub-module is required.
- A 2-stage cascade wrapper `updown_modcount_chain` is a separate, later block and is out of scope here.

## Test plan
- n=4, reset, then `M`=9, wrap, up, `E`=1 for 12 cycles → `Q` goes 1..9, 0, 1, 2; `Cout`=1 only in the cycle `Q`=9.
- n=4, `M`=5, saturate, down from load `R`=2 → `Q` goes 1, 0, then holds 0; `Cout`=1 each cycle at 0 while `E`=1.
- n=4, `M`=3, one-shot, up from 0 → `Q` goes 1, 2, 3, and `Done`=1 in the same edge `Q`=3. Further `E` leaves `Q`=3; `L` with `R`=0 → `Q`=0, `Done`=0.
- Load `R`=12 with `M`=7 → `Q`=7. With `L`=`E`=1 in the same cycle → load only. `M` lowered to 4 while `Q`=7: up-wrap → 0, down → 4.
- Reset asserted mid-count (`Q`=6) and while in DONE → next edge `Q`=0, `Done`=0, counting resumes normally.
- Two instances chained (`Cout`→`E`), n=4, `M`=9 each, wrap, up → combined value goes 00..99 then 00; upper stage steps exactly once per lower-stage wrap.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the modulus counters: end-behaviour modes and FSM states.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/updown_modcount.sv
// Up/down counter over 0..M with wrap/saturate/one-shot ends; Q and Done registered (1 cycle),
// Cout is combinational and drives the next stage's E, so cascades have no backpressure beyond E.
module updown_modcount
  import counter_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [n-1:0] R,
  input  logic [n-1:0] M,
  input  logic         L,
  input  logic         E,
  input  logic         up_down,
  input  logic [1:0]   mode,
  output logic [n-1:0] Q,
  output logic         Cout,
  output logic         Done
);

  localparam logic [n-1:0] ONE = n'(1);

  state_t       state;
  logic         bnd;
  logic         term_hit;
  logic [n-1:0] step_q;

  assign bnd = up_down ? (Q >= M) : (Q == '0);

  // Next value for an enabled step; reserved mode 11 falls through to wrap.
  always_comb begin
    step_q = Q;
    if (!bnd) begin
      if (up_down)
        step_q = Q + ONE;
      else if (Q > M)
        step_q = M;
      else
        step_q = Q - ONE;
    end else if (mode == MODE_SAT || mode == MODE_ONESHOT) begin
      if (up_down && Q > M)
        step_q = M;
    end else begin
      step_q = up_down ? '0 : M;
    end
  end

  assign term_hit = up_down ? (step_q == M) : (step_q == '0);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      Q     <= '0;
      state <= ST_COUNT;
    end else if (L) begin
      Q     <= (R > M) ? M : R;
      state <= ST_COUNT;
    end else if (E && state == ST_COUNT) begin
      Q <= step_q;
      if (mode == MODE_ONESHOT && (bnd || term_hit))
        state <= ST_DONE;
    end
  end

  assign Cout = E & ~L & Resetn & (state == ST_COUNT) & bnd;
  assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_updown_modcount.sv
// Directed self-checking bench for updown_modcount (n=4), including a two-stage decimal cascade.
module tb_updown_modcount;

  logic       Clock;
  logic       Resetn;
  logic [3:0] R, M;
  logic       L, E, up_down;
  logic [1:0] mode;
  logic [3:0] Q;
  logic       Cout, Done;

  logic       c_resetn, c_e, c_l, c_up;
  logic [3:0] c_r, c_m;
  logic [1:0] c_mode;
  logic [3:0] lo_q, hi_q;
  logic       lo_cout, hi_cout, lo_done, hi_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  updown_modcount #(.n(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .R(R), .M(M), .L(L), .E(E),
    .up_down(up_down), .mode(mode), .Q(Q), .Cout(Cout), .Done(Done)
  );

  updown_modcount #(.n(4)) lo_stage (
    .Clock(Clock), .Resetn(c_resetn), .R(c_r), .M(c_m), .L(c_l), .E(c_e),
    .up_down(c_up), .mode(c_mode), .Q(lo_q), .Cout(lo_cout), .Done(lo_done)
  );

  updown_modcount #(.n(4)) hi_stage (
    .Clock(Clock), .Resetn(c_resetn), .R(c_r), .M(c_m), .L(c_l), .E(lo_cout),
    .up_down(c_up), .mode(c_mode), .Q(hi_q), .Cout(hi_cout), .Done(hi_done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; L = 1'b0; E = 1'b1; up_down = 1'b1; mode = 2'b00; M = 4'd9; R = 4'd0;
    #1;
    total_cnt++;
    if (Cout !== 1'b0) $display("FAIL reset_cout got %b want 0", Cout); else pass_cnt++;
    step();
    total_cnt++;
    if (Q !== 4'd0) $display("FAIL reset_q got %0d want 0", Q); else pass_cnt++;
    total_cnt++;
    if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else pass_cnt++;
    Resetn = 1'b1; E = 1'b0;
  endtask

  task automatic test_wrap_up();
    int expq = 0;
    M = 4'd9; mode = 2'b00; up_down = 1'b1; L = 1'b0; E = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      #1;
      total_cnt++;
      if (Cout !== (expq == 9)) $display("FAIL wrap_cout i=%0d got %b want %b", i, Cout, (expq == 9));
      else pass_cnt++;
      step();
      expq = i % 10;
      total_cnt++;
      if (Q !== 4'(expq)) $display("FAIL wrap_q i=%0d got %0d want %0d", i, Q, expq); else pass_cnt++;
    end
    E = 1'b0;
  endtask

  task automatic test_sat_down();
    int expq = 2;
    M = 4'd5; mode = 2'b01; up_down = 1'b0; L = 1'b1; R = 4'd2; E = 1'b0;
    step();
    total_cnt++;
    if (Q !== 4'd2) $display("FAIL sat_load got %0d want 2", Q); else pass_cnt++;
    L = 1'b0; E = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if (Cout !== (expq == 0)) $display("FAIL sat_cout i=%0d got %b want %b", i, Cout, (expq == 0));
      else pass_cnt++;
      step();
      expq = (expq == 0) ? 0 : expq - 1;
      total_cnt++;
      if (Q !== 4'(expq) || Done !== 1'b0)
        $display("FAIL sat_q i=%0d got %0d/%b want %0d/0", i, Q, Done, expq);
      else pass_cnt++;
    end
    E = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [3:0] eq [3] = '{4'd1, 4'd2, 4'd3};
    logic       ed [3] = '{1'b0, 1'b0, 1'b1};
    M = 4'd3; mode = 2'b10; up_down = 1'b1; L = 1'b1; R = 4'd0; E = 1'b0;
    step();
    L = 1'b0; E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (Q !== eq[i] || Done !== ed[i])
        $display("FAIL oneshot_run i=%0d got %0d/%b want %0d/%b", i, Q, Done, eq[i], ed[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (Cout !== 1'b0) $display("FAIL oneshot_cout_done got %b want 0", Cout); else pass_cnt++;
    step();
    total_cnt++;
    if (Q !== 4'd3 || Done !== 1'b1) $display("FAIL oneshot_hold got %0d/%b want 3/1", Q, Done); else pass_cnt++;
    mode = 2'b00;
    step();
    total_cnt++;
    if (Q !== 4'd3 || Done !== 1'b1) $display("FAIL oneshot_modechg got %0d/%b want 3/1", Q, Done); else pass_cnt++;
    mode = 2'b10; L = 1'b1; R = 4'd0;
    step();
    total_cnt++;
    if (Q !== 4'd0 || Done !== 1'b0) $display("FAIL oneshot_reload got %0d/%b want 0/0", Q, Done); else pass_cnt++;
    R = 4'd3; E = 1'b0;
    step();
    L = 1'b0; E = 1'b1;
    #1;
    total_cnt++;
    if (Cout !== 1'b1) $display("FAIL oneshot_bnd_cout got %b want 1", Cout); else pass_cnt++;
    step();
    total_cnt++;
    if (Q !== 4'd3 || Done !== 1'b1) $display("FAIL oneshot_bnd got %0d/%b want 3/1", Q, Done); else pass_cnt++;
    L = 1'b1; R = 4'd0; E = 1'b0;
    step();
    L = 1'b0;
  endtask

  task automatic test_load_clamp();
    mode = 2'b00; M = 4'd7; L = 1'b1; R = 4'd12; E = 1'b0; up_down = 1'b1;
    step();
    total_cnt++;
    if (Q !== 4'd7) $display("FAIL clamp_q got %0d want 7", Q); else pass_cnt++;
    E = 1'b1; R = 4'd2;
    #1;
    total_cnt++;
    if (Cout !== 1'b0) $display("FAIL load_en_cout got %b want 0", Cout); else pass_cnt++;
    step();
    total_cnt++;
    if (Q !== 4'd2) $display("FAIL load_en_q got %0d want 2", Q); else pass_cnt++;
    R = 4'd7; E = 1'b0;
    step();
    L = 1'b0; M = 4'd4; E = 1'b1;
    #1;
    total_cnt++;
    if (Cout !== 1'b1) $display("FAIL lowm_cout got %b want 1", Cout); else pass_cnt++;
    step();
    total_cnt++;
    if (Q !== 4'd0) $display("FAIL lowm_up_q got %0d want 0", Q); else pass_cnt++;
    L = 1'b1; R = 4'd7; M = 4'd7; E = 1'b0;
    step();
    L = 1'b0; M = 4'd4; up_down = 1'b0; E = 1'b1;
    step();
    total_cnt++;
    if (Q !== 4'd4) $display("FAIL lowm_dn_q got %0d want 4", Q); else pass_cnt++;
    step();
    total_cnt++;
    if (Q !== 4'd3) $display("FAIL lowm_dn2_q got %0d want 3", Q); else pass_cnt++;
    E = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode = 2'b00; M = 4'd9; up_down = 1'b1; L = 1'b1; R = 4'd5; E = 1'b0;
    step();
    L = 1'b0; E = 1'b1;
    step();
    total_cnt++;
    if (Q !== 4'd6) $display("FAIL mid_pre got %0d want 6", Q); else pass_cnt++;
    Resetn = 1'b0; L = 1'b1; R = 4'd3;
    step();
    total_cnt++;
    if (Q !== 4'd0 || Done !== 1'b0) $display("FAIL mid_reset got %0d/%b want 0/0", Q, Done); else pass_cnt++;
    Resetn = 1'b1; L = 1'b0;
    step();
    total_cnt++;
    if (Q !== 4'd1) $display("FAIL mid_resume got %0d want 1", Q); else pass_cnt++;
    mode = 2'b10; M = 4'd2;
    step();
    total_cnt++;
    if (Q !== 4'd2 || Done !== 1'b1) $display("FAIL done_pre got %0d/%b want 2/1", Q, Done); else pass_cnt++;
    Resetn = 1'b0;
    step();
    total_cnt++;
    if (Q !== 4'd0 || Done !== 1'b0) $display("FAIL done_reset got %0d/%b want 0/0", Q, Done); else pass_cnt++;
    Resetn = 1'b1;
    step();
    total_cnt++;
    if (Q !== 4'd1 || Done !== 1'b0) $display("FAIL done_resume got %0d/%b want 1/0", Q, Done); else pass_cnt++;
    E = 1'b0;
  endtask

  task automatic test_m_zero();
    mode = 2'b00; M = 4'd0; up_down = 1'b1; L = 1'b1; R = 4'd5; E = 1'b0;
    step();
    total_cnt++;
    if (Q !== 4'd0) $display("FAIL m0_load got %0d want 0", Q); else pass_cnt++;
    L = 1'b0; E = 1'b1;
    #1;
    total_cnt++;
    if (Cout !== 1'b1) $display("FAIL m0_cout got %b want 1", Cout); else pass_cnt++;
    step();
    mode = 2'b01; up_down = 1'b0;
    step();
    total_cnt++;
    if (Q !== 4'd0 || Cout !== 1'b1) $display("FAIL m0_sat got %0d/%b want 0/1", Q, Cout); else pass_cnt++;
    mode = 2'b10; up_down = 1'b1;
    step();
    total_cnt++;
    if (Q !== 4'd0 || Done !== 1'b1) $display("FAIL m0_oneshot got %0d/%b want 0/1", Q, Done); else pass_cnt++;
    E = 1'b0; Resetn = 1'b0;
    step();
    Resetn = 1'b1;
  endtask

  task automatic test_chain();
    int got;
    c_resetn = 1'b0; c_e = 1'b0;
    step();
    c_resetn = 1'b1; c_e = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      got = int'(hi_q) * 10 + int'(lo_q);
      total_cnt++;
      if (got !== (i % 100)) $display("FAIL chain_val i=%0d got %0d want %0d", i, got, i % 100);
      else pass_cnt++;
    end
    c_e = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0; R = '0; M = '0; L = 1'b0; E = 1'b0; up_down = 1'b1; mode = 2'b00;
    c_resetn = 1'b0; c_e = 1'b0; c_l = 1'b0; c_up = 1'b1; c_r = 4'd0; c_m = 4'd9; c_mode = 2'b00;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_oneshot();
    test_load_clamp();
    test_reset_mid();
    test_m_zero();
    test_chain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
